// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory port between an icache and a dcache.
// Latency: a request seen in IDLE is granted next cycle; wait drops in the
//   grant cycle once ramwait=0. There is always one IDLE cycle between grants.
// Backpressure: ramwait stalls the granted requester. The other requester
//   keeps its wait at 1 until it is granted.
//
// Ports:
//   CLK, nRST                     clock, asynchronous active-low reset
//   iREN, iaddr, iwait, iload     icache read-only request/response
//   dREN, dWEN, daddr, dstore,
//   dwait, dload                  dcache read/write request/response
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload, ramwait    shared memory port
//
// Define ARB_FAIR_EN for round-robin arbitration between the two caches.
// When it is not defined, the dcache has strict priority.

module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  // icache
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  // dcache
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  // memory
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramwait
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t state, next_state;
  logic   d_req;

  assign d_req = dREN | dWEN;

  // The read data is passed straight through to both caches. Each cache
  // treats it as valid only while its own wait signal is low.
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

`ifdef ARB_FAIR_EN
  // Holds the requester whose access last completed. An aborted access does
  // not count as a completion.
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_t;

  last_t last_grant;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant <= LAST_I;
    end else if (state == IGNT && iREN && !ramwait) begin
      last_grant <= LAST_I;
    end else if (state == DGNT && d_req && !ramwait) begin
      last_grant <= LAST_D;
    end
  end
`endif

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;

    case (state)
      IDLE: begin
`ifdef ARB_FAIR_EN
        if (d_req && iREN)
          next_state = (last_grant == LAST_D) ? IGNT : DGNT;
        else if (d_req)
          next_state = DGNT;
        else if (iREN)
          next_state = IGNT;
        else
          next_state = IDLE;
`else
        if (d_req)
          next_state = DGNT;
        else if (iREN)
          next_state = IGNT;
        else
          next_state = IDLE;
`endif
      end

      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        // If the request is withdrawn, the access is aborted and wait stays high.
        iwait   = ~(iREN & ~ramwait);
        // Stay here only while the access is still running. Completion and
        // abort both return to IDLE.
        next_state = (iREN && ramwait) ? IGNT : IDLE;
      end

      DGNT: begin
        // When both strobes are set, the access is treated as a write.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~(d_req & ~ramwait);
        next_state = (d_req && ramwait) ? DGNT : IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramwait;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.ADDR_W(32), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
  );

  // Moves to the next cycle. Inputs are changed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drops all requests and lets the arbiter return to IDLE.
  task automatic settle();
    iREN = 0; dREN = 0; dWEN = 0; ramwait = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramwait = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL reset_ramREN got=%b exp=0", ramREN); end
    total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL reset_ramWEN got=%b exp=0", ramWEN); end
    total++; if (iwait !== 1'b1) begin bad++; $display("FAIL reset_iwait got=%b exp=1", iwait); end
    total++; if (dwait !== 1'b1) begin bad++; $display("FAIL reset_dwait got=%b exp=1", dwait); end
    total++; if (ramaddr !== 32'h0) begin bad++; $display("FAIL reset_ramaddr got=%h exp=0", ramaddr); end
    tick();
    nRST = 1;
    tick();
  endtask

  task automatic test_iread();
    int rd_cnt, lo_cnt;
    rd_cnt = 0; lo_cnt = 0;
    iREN = 1; iaddr = 32'h40; ramwait = 1; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    total++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      bad++; $display("FAIL iread_idle ramREN=%b iwait=%b exp 0/1", ramREN, iwait);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      ramwait = (c == 3) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (ramREN === 1'b1) rd_cnt++;
      if (iwait === 1'b0) begin
        lo_cnt++;
        total++; if (iload !== 32'hDEADBEEF) begin bad++; $display("FAIL iread_iload got=%h exp=deadbeef", iload); end
      end
      if (c == 0) begin
        total++; if (ramaddr !== 32'h40) begin bad++; $display("FAIL iread_ramaddr got=%h exp=40", ramaddr); end
      end
    end
    total++; if (rd_cnt != 4) begin bad++; $display("FAIL iread_ren_cycles got=%0d exp=4", rd_cnt); end
    total++; if (lo_cnt != 1) begin bad++; $display("FAIL iread_iwait_low got=%0d exp=1", lo_cnt); end
    // Keep iREN high here. In IDLE ramREN is 0, while a stuck IGNT would keep it at 1.
    tick();
    ramwait = 1;
    @(negedge CLK);
    total++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      bad++; $display("FAIL iread_back_idle ramREN=%b iwait=%b exp 0/1", ramREN, iwait);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    dWEN = 1; daddr = 32'h100; dstore = 32'hA5A5A5A5; ramwait = 1;
    tick();
    @(negedge CLK);
    total++; if (ramWEN !== 1'b1) begin bad++; $display("FAIL rstmid_pre_ramWEN got=%b exp=1", ramWEN); end
    #1 nRST = 0;
    #1;
    total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL rstmid_ramWEN got=%b exp=0", ramWEN); end
    total++; if (dwait !== 1'b1) begin bad++; $display("FAIL rstmid_dwait got=%b exp=1", dwait); end
    total++; if (ramaddr !== 32'h0) begin bad++; $display("FAIL rstmid_ramaddr got=%h exp=0", ramaddr); end
    dWEN = 0;
    tick();
    nRST = 1;
    settle();
  endtask

  task automatic test_priority();
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678; ramwait = 0;
    tick();
    @(negedge CLK);
    total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin
      bad++; $display("FAIL prio_dgnt_strobes ramWEN=%b ramREN=%b exp 1/0", ramWEN, ramREN);
    end
    total++; if (ramstore !== 32'h12345678) begin bad++; $display("FAIL prio_ramstore got=%h exp=12345678", ramstore); end
    total++; if (ramaddr !== 32'h80) begin bad++; $display("FAIL prio_ramaddr got=%h exp=80", ramaddr); end
    total++; if (dwait !== 1'b0 || iwait !== 1'b1) begin
      bad++; $display("FAIL prio_waits dwait=%b iwait=%b exp 0/1", dwait, iwait);
    end
    tick();
    dWEN = 0;
    @(negedge CLK);
    total++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || iwait !== 1'b1) begin
      bad++; $display("FAIL prio_turnaround ramWEN=%b ramREN=%b iwait=%b exp 0/0/1", ramWEN, ramREN, iwait);
    end
    tick();
    @(negedge CLK);
    total++; if (ramREN !== 1'b1 || ramaddr !== 32'h44 || iwait !== 1'b0) begin
      bad++; $display("FAIL prio_ignt ramREN=%b ramaddr=%h iwait=%b exp 1/44/0", ramREN, ramaddr, iwait);
    end
    settle();
  endtask

  task automatic test_fairness();
    int exp_g[6];
    int obs;
`ifdef ARB_FAIR_EN
    exp_g = '{0, 2, 0, 1, 0, 2};
`else
    exp_g = '{0, 2, 0, 2, 0, 2};
`endif
    dREN = 1; daddr = 32'h200; iREN = 1; iaddr = 32'h300; ramwait = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      @(negedge CLK);
      obs = (dwait === 1'b0) ? 2 : (iwait === 1'b0) ? 1 : 0;
      total++; if (obs != exp_g[c]) begin
        bad++; $display("FAIL fair_cycle%0d grant got=%0d exp=%0d", c, obs, exp_g[c]);
      end
    end
    settle();
  endtask

  task automatic test_abort();
    dREN = 1; daddr = 32'h500; ramwait = 1;
    tick();
    @(negedge CLK);
    total++; if (ramREN !== 1'b1) begin bad++; $display("FAIL abort_first_ramREN got=%b exp=1", ramREN); end
    tick();
    dREN = 0;
    @(negedge CLK);
    total++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin
      bad++; $display("FAIL abort_same_cycle ramREN=%b dwait=%b exp 0/1", ramREN, dwait);
    end
    // Assert dREN again. The arbiter is expected to be in IDLE, so no strobe yet.
    tick();
    dREN = 1;
    @(negedge CLK);
    total++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin
      bad++; $display("FAIL abort_idle_next ramREN=%b dwait=%b exp 0/1", ramREN, dwait);
    end
    tick();
    @(negedge CLK);
    total++; if (ramREN !== 1'b1) begin bad++; $display("FAIL abort_regrant ramREN=%b exp=1", ramREN); end
    settle();
  endtask

  task automatic test_rw_both();
    dREN = 1; dWEN = 1; daddr = 32'h600; dstore = 32'hCAFEF00D; ramwait = 0;
    tick();
    @(negedge CLK);
    total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin
      bad++; $display("FAIL rw_both ramWEN=%b ramREN=%b exp 1/0", ramWEN, ramREN);
    end
    total++; if (dwait !== 1'b0 || ramstore !== 32'hCAFEF00D) begin
      bad++; $display("FAIL rw_both_done dwait=%b ramstore=%h exp 0/cafef00d", dwait, ramstore);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_iread();
    test_reset_mid();
    test_priority();
    test_fairness();
    test_abort();
    test_rw_both();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 The block SHALL have parameter WORD_W, default 32, data word width.
REQ-003 The block SHALL have port CLK  input  1  rising-edge clock.
REQ-004 The block SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port iREN  input  1  icache read request.
REQ-006 The block SHALL have port iaddr  input  ADDR_W  icache address.
REQ-007 The block SHALL have port iwait  output  1  icache stall; 0 = iload valid this cycle.
REQ-008 The block SHALL have port iload  output  WORD_W  icache read data.
REQ-009 The block SHALL have port dREN  input  1  dcache read request.
REQ-010 The block SHALL have port dWEN  input  1  dcache write request.
REQ-011 The block SHALL have port daddr  input  ADDR_W  dcache address.
REQ-012 The block SHALL have port dstore  input  WORD_W  dcache write data.
REQ-013 The block SHALL have port dwait  output  1  dcache stall; 0 = access complete this cycle.
REQ-014 The block SHALL have port dload  output  WORD_W  dcache read data.
REQ-015 The block SHALL have ports ramREN and ramWEN  output  1  memory read/write strobes.
REQ-016 The block SHALL have ports ramaddr (output, ADDR_W), ramstore (output, WORD_W) and ramload (input, WORD_W), the memory address, write data and read data.
REQ-017 The block SHALL have port ramwait  input  1  memory busy; 0 = current access completes this cycle.

Function
REQ-018 The FSM SHALL have states IDLE, IGNT and DGNT, held in a registered state variable.
REQ-019 In IDLE, next state SHALL be DGNT if dREN|dWEN, else IGNT if iREN, else IDLE (subject to REQ-029).
REQ-020 In IDLE, ramREN=ramWEN=0, iwait=dwait=1 and ramaddr=0.
REQ-021 In IGNT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, iwait=ramwait, dwait=1.
REQ-022 In DGNT: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore, dwait=ramwait, iwait=1.
REQ-023 iload and dload SHALL combinationally equal ramload in all states; validity is indicated only by the corresponding wait low.
REQ-024 A granted state SHALL hold while its request is asserted and ramwait=1, and SHALL return to IDLE on the cycle after ramwait=0 (completion), giving one idle turnaround cycle between grants.
REQ-025 A granted requester deasserting its request mid-access SHALL cause an abort: strobes drop the same cycle, wait stays 1, and next state is IDLE.
REQ-026 Simultaneous dREN and dWEN SHALL be treated as a write.
REQ-027 A non-granted requester SHALL see wait=1 and SHALL have no effect on memory outputs.
REQ-028 Minimum latency from request (in IDLE) to wait low SHALL be 1 cycle with ramwait=0 in the grant cycle.

Reset
REQ-029 nRST low SHALL force state=IDLE and last_grant=I immediately, yielding ramREN=ramWEN=0, iwait=dwait=1 and ramaddr=0; reset during a grant SHALL abort the access without completion.

Configuration
REQ-030 With macro ARB_FAIR_EN defined, a last_grant register SHALL record the requester of each completed access, and in IDLE with both requests pending the requester not equal to last_grant SHALL win.
REQ-031 Without ARB_FAIR_EN, dcache SHALL have strict priority per REQ-019, and no last_grant register SHALL exist.

Verification
REQ-032 Reset mid-DGNT write (daddr=0x100) -> ramWEN=0, dwait=1, state IDLE immediately.
REQ-033 iREN only, iaddr=0x40, ramwait=1 for 3 cycles then 0, ramload=0xDEADBEEF -> ramREN=1 for 4 cycles, iwait low once with iload=0xDEADBEEF, then IDLE.
REQ-034 iREN and dWEN together, daddr=0x80, dstore=0x12345678 -> DGNT first with ramWEN=1 and ramstore=0x12345678; after completion and one IDLE cycle, IGNT.
REQ-035 With ARB_FAIR_EN: dREN held continuously, iREN pending -> grants alternate D,I,D; without ARB_FAIR_EN -> icache starves while dREN is held.
REQ-036 dREN dropped in the second DGNT cycle with ramwait=1 -> ramREN=0 the same cycle, dwait never low, IDLE next.
REQ-037 dREN=dWEN=1 -> ramWEN=1 and ramREN=0.
